// File: rtl/mult_add16_pkg.sv
// rtl/mult_add16_pkg.sv - shared widths, counter sizes and FSM state type
package mult_add16_pkg;

  localparam int MUL_W     = 8;
  localparam int SUM_W     = 16;
  localparam int SLICE_W   = 4;
  localparam int N_SLICES  = SUM_W / SLICE_W;
  localparam int MUL_CNT_W = 3;
  localparam int ADD_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_add16_if.sv
// rtl/mult_add16_if.sv - operand/result bundle for the multiplier/adder pair
interface mult_add16_if;
  import mult_add16_pkg::*;

  logic               mul_rst_n;
  logic [MUL_W-1:0]   mul_x;
  logic [MUL_W-1:0]   mul_y;
  logic [SUM_W-1:0]   mul_result;
  logic               mul_done;

  logic               add_rst_n;
  logic [SUM_W-1:0]   add_x;
  logic [SUM_W-1:0]   add_y;
  logic [SUM_W-1:0]   add_result;
  logic               add_done;

  // When set, the adder runs off the multiplier: reset from mul_done, x from the product
  logic               chain;

  modport master (
    output mul_rst_n, mul_x, mul_y, add_rst_n, add_x, add_y, chain,
    input  mul_result, mul_done, add_result, add_done
  );

  modport slave (
    input  mul_rst_n, mul_x, mul_y, add_rst_n, add_x, add_y, chain,
    output mul_result, mul_done, add_result, add_done
  );

endinterface

// File: rtl/mult_add16_add_slice4.sv
// rtl/mult_add16_add_slice4.sv - 4-bit ripple adder with carry in/out
module add_slice4
  import mult_add16_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/mult_add16_adder16.sv
// rtl/mult_add16_adder16.sv - iterative 16-bit modulo adder, one 4-bit slice per cycle
module adder16
  import mult_add16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [SUM_W-1:0] result,
  output logic             done,
  input  logic [SUM_W-1:0] x,
  input  logic [SUM_W-1:0] y
);

  state_t               r_state;
  logic [ADD_CNT_W-1:0] r_slice;
  logic                 r_done;
  logic [SUM_W-1:0]     r_x;
  logic [SUM_W-1:0]     r_y;
  logic [SUM_W-1:0]     r_sum;
  logic                 r_carry;
  logic [SLICE_W-1:0]   w_s;
  logic                 w_cout;
  int                   w_lsb;

  assign w_lsb = int'(r_slice) * SLICE_W;

  add_slice4 u_slice (
    .i_a    (r_x[w_lsb +: SLICE_W]),
    .i_b    (r_y[w_lsb +: SLICE_W]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_slice <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_slice <= '0;
        end
        RUN: begin
          r_slice <= r_slice + 1'b1;
          if (r_slice == ADD_CNT_W'(N_SLICES - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Carry out of the top slice is kept in r_carry but never used, so the sum wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == IDLE) begin
      r_x     <= x;
      r_y     <= y;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[w_lsb +: SLICE_W] <= w_s;
      r_carry                 <= w_cout;
    end
  end

  assign result = r_sum;
  assign done   = r_done;

endmodule

// File: rtl/mult_add16_mult16.sv
// rtl/mult_add16_mult16.sv - iterative 8x8->16 unsigned shift-add multiplier
module mult16
  import mult_add16_pkg::*;
(
  output logic [SUM_W-1:0] result,
  output logic             done,
  input  logic             reset,
  input  logic             clk,
  input  logic [MUL_W-1:0] x,
  input  logic [MUL_W-1:0] y
);

  state_t               r_state;
  logic [MUL_CNT_W-1:0] r_count;
  logic                 r_done;
  logic [MUL_W-1:0]     r_x;
  logic [MUL_W-1:0]     r_y;
  logic [SUM_W-1:0]     r_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_count <= '0;
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (r_count == MUL_CNT_W'(MUL_W - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_prod <= '0;
    end else if (r_state == IDLE) begin
      r_x    <= x;
      r_y    <= y;
      r_prod <= '0;
    end else if (r_state == RUN && r_y[r_count]) begin
      r_prod <= r_prod + (SUM_W'(r_x) << r_count);
    end
  end

  assign result = r_prod;
  assign done   = r_done;

endmodule

// File: rtl/mult_add16.sv
// rtl/mult_add16.sv - multiplier/adder pair with optional mult->add chaining
module mult_add16
  import mult_add16_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  mult_add16_if.slave      bus
);

  logic [SUM_W-1:0] w_mul_result;
  logic             w_mul_done;
  logic [SUM_W-1:0] w_add_result;
  logic             w_add_done;
  logic             w_mul_rst_n;
  logic             w_add_rst_n;
  logic [SUM_W-1:0] w_add_x;

  assign w_mul_rst_n = i_rst_n & bus.mul_rst_n;
  assign w_add_rst_n = bus.chain ? (i_rst_n & w_mul_done) : (i_rst_n & bus.add_rst_n);
  assign w_add_x     = bus.chain ? w_mul_result : bus.add_x;

  mult16 u_mult (w_mul_result, w_mul_done, w_mul_rst_n, i_clk, bus.mul_x, bus.mul_y);

  adder16 u_add (
    .clk    (i_clk),
    .reset  (w_add_rst_n),
    .result (w_add_result),
    .done   (w_add_done),
    .x      (w_add_x),
    .y      (bus.add_y)
  );

  assign bus.mul_result = w_mul_result;
  assign bus.mul_done   = w_mul_done;
  assign bus.add_result = w_add_result;
  assign bus.add_done   = w_add_done;

endmodule

// File: tb/tb_mult_add16.sv
// tb/tb_mult_add16.sv - directed self-checking bench for mult_add16
module tb_mult_add16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mult_add16_if bus ();

  mult_add16 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mul_x = 8'd9;
    bus.mul_y = 8'd9;
    bus.add_x = 16'h1234;
    bus.add_y = 16'h1111;
    repeat (3) step();
    n_cmp++; if (bus.mul_result !== 16'd0) begin n_bad++; $display("FAIL reset_mul_result got %0d expected 0", bus.mul_result); end
    n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL reset_mul_done got %b expected 0", bus.mul_done); end
    n_cmp++; if (bus.add_result !== 16'd0) begin n_bad++; $display("FAIL reset_add_result got %0d expected 0", bus.add_result); end
    n_cmp++; if (bus.add_done !== 1'b0) begin n_bad++; $display("FAIL reset_add_done got %b expected 0", bus.add_done); end
  endtask

  task automatic test_mult_basic();
    bus.mul_x = 8'd3;
    bus.mul_y = 8'd2;
    bus.mul_rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      n_cmp++;
      if (bus.mul_done !== (e == 9)) begin
        n_bad++; $display("FAIL mul_basic_done_edge%0d got %b expected %b", e, bus.mul_done, (e == 9));
      end
    end
    n_cmp++; if (bus.mul_result !== 16'd6) begin n_bad++; $display("FAIL mul_basic_result got %0d expected 6", bus.mul_result); end
    bus.mul_x = 8'd200;
    bus.mul_y = 8'd100;
    repeat (20) step();
    n_cmp++; if (bus.mul_done !== 1'b1) begin n_bad++; $display("FAIL mul_basic_done_hold got %b expected 1", bus.mul_done); end
    n_cmp++; if (bus.mul_result !== 16'd6) begin n_bad++; $display("FAIL mul_basic_result_hold got %0d expected 6", bus.mul_result); end
    bus.mul_rst_n = 1'b0;
    #1;
  endtask

  task automatic test_mult_vectors();
    logic [7:0]  xs [4];
    logic [7:0]  ys [4];
    logic [15:0] ps [4];
    xs = '{8'd255, 8'd0,   8'd15, 8'd128};
    ys = '{8'd255, 8'd200, 8'd17, 8'd2};
    ps = '{16'hFE01, 16'd0, 16'd255, 16'd256};
    for (int i = 0; i < 4; i++) begin
      bus.mul_x = xs[i];
      bus.mul_y = ys[i];
      bus.mul_rst_n = 1'b1;
      repeat (8) step();
      n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL mul_vec%0d_done_edge8 got %b expected 0", i, bus.mul_done); end
      step();
      n_cmp++; if (bus.mul_done !== 1'b1) begin n_bad++; $display("FAIL mul_vec%0d_done_edge9 got %b expected 1", i, bus.mul_done); end
      n_cmp++; if (bus.mul_result !== ps[i]) begin n_bad++; $display("FAIL mul_vec%0d_result got %0d expected %0d", i, bus.mul_result, ps[i]); end
      bus.mul_rst_n = 1'b0;
      #1;
    end
  endtask

  task automatic test_adder();
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    logic [15:0] ss [4];
    xs = '{16'hFFFF, 16'd6,   16'h0FFF, 16'h8000};
    ys = '{16'h0001, 16'd100, 16'h0001, 16'h8000};
    ss = '{16'h0000, 16'd106, 16'h1000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      bus.add_x = xs[i];
      bus.add_y = ys[i];
      bus.add_rst_n = 1'b1;
      repeat (4) step();
      n_cmp++; if (bus.add_done !== 1'b0) begin n_bad++; $display("FAIL add_vec%0d_done_edge4 got %b expected 0", i, bus.add_done); end
      step();
      n_cmp++; if (bus.add_done !== 1'b1) begin n_bad++; $display("FAIL add_vec%0d_done_edge5 got %b expected 1", i, bus.add_done); end
      n_cmp++; if (bus.add_result !== ss[i]) begin n_bad++; $display("FAIL add_vec%0d_result got %h expected %h", i, bus.add_result, ss[i]); end
      bus.add_rst_n = 1'b0;
      #1;
    end
  endtask

  task automatic test_mult_abort();
    bus.mul_x = 8'd255;
    bus.mul_y = 8'd255;
    bus.mul_rst_n = 1'b1;
    repeat (4) step();
    n_cmp++; if (bus.mul_result !== 16'd1785) begin n_bad++; $display("FAIL abort_partial got %0d expected 1785", bus.mul_result); end
    bus.mul_rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mul_result !== 16'd0) begin n_bad++; $display("FAIL abort_result_now got %0d expected 0", bus.mul_result); end
    n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL abort_done_now got %b expected 0", bus.mul_done); end
    step();
    bus.mul_x = 8'd7;
    bus.mul_y = 8'd9;
    bus.mul_rst_n = 1'b1;
    repeat (8) step();
    n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL abort_rerun_done_edge8 got %b expected 0", bus.mul_done); end
    step();
    n_cmp++; if (bus.mul_result !== 16'd63) begin n_bad++; $display("FAIL abort_rerun_result got %0d expected 63", bus.mul_result); end
    bus.mul_rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset_glitch();
    bus.mul_x = 8'd11;
    bus.mul_y = 8'd13;
    bus.mul_rst_n = 1'b1;
    #2;
    bus.mul_rst_n = 1'b0;
    repeat (12) step();
    n_cmp++; if (bus.mul_result !== 16'd0) begin n_bad++; $display("FAIL glitch_result got %0d expected 0", bus.mul_result); end
    n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL glitch_done got %b expected 0", bus.mul_done); end
  endtask

  task automatic test_input_change();
    bus.mul_x = 8'd4;
    bus.mul_y = 8'd2;
    bus.mul_rst_n = 1'b1;
    step();
    bus.mul_x = 8'd9;
    bus.mul_y = 8'd9;
    repeat (8) step();
    n_cmp++; if (bus.mul_done !== 1'b1) begin n_bad++; $display("FAIL change_done got %b expected 1", bus.mul_done); end
    n_cmp++; if (bus.mul_result !== 16'd8) begin n_bad++; $display("FAIL change_result got %0d expected 8", bus.mul_result); end
    bus.mul_rst_n = 1'b0;
    #1;
  endtask

  task automatic test_chain();
    bus.chain = 1'b1;
    bus.add_x = 16'hAAAA;
    bus.add_y = 16'd10;
    bus.mul_x = 8'd5;
    bus.mul_y = 8'd2;
    bus.mul_rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 9) begin
        n_cmp++; if (bus.mul_done !== 1'b1) begin n_bad++; $display("FAIL chain_mul_done_edge9 got %b expected 1", bus.mul_done); end
      end
      if (e >= 13) begin
        n_cmp++;
        if (bus.add_done !== (e == 14)) begin
          n_bad++; $display("FAIL chain_add_done_edge%0d got %b expected %b", e, bus.add_done, (e == 14));
        end
      end
    end
    n_cmp++; if (bus.add_result !== 16'd20) begin n_bad++; $display("FAIL chain_add_result got %0d expected 20", bus.add_result); end
    bus.mul_rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.add_done !== 1'b0) begin n_bad++; $display("FAIL chain_add_done_after_reset got %b expected 0", bus.add_done); end
    bus.chain = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.mul_rst_n = 1'b0;
    bus.add_rst_n = 1'b0;
    bus.chain = 1'b0;
    bus.mul_x = '0;
    bus.mul_y = '0;
    bus.add_x = '0;
    bus.add_y = '0;
    test_reset();
    rst_n = 1'b1;
    test_mult_basic();
    test_mult_vectors();
    test_adder();
    test_mult_abort();
    test_reset_glitch();
    test_input_change();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_add16.md
# mult_add16

Arithmetic unit pair for the MAC datapath: `mult16`, an iterative 8×8→16 unsigned multiplier, and `adder16`, an iterative 16-bit modulo adder. Both units are sequential and start on reset release. Each raises a sticky `done` level when its result is valid. The MAC controller chains them as follows: the multiplier's `done` releases the adder's reset, and the controller latches the sum on the adder's `done` rising edge.

## Interface
Parameters (shared package, not overridable per instance):
- `MUL_W`, 8, operand width of `mult16`
- `SUM_W`, 16, operand/result width of both units
- `SLICE_W`, 4, bits added per cycle in `adder16`

`mult16` ports (positional order: result, done, reset, clk, x, y):
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `result` out 16: unsigned product x*y
- `done` out 1: product valid, held until reset
- `x` in 8: multiplicand
- `y` in 8: multiplier

`adder16` ports (named):
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `result` out 16: (x+y) mod 2^16
- `done` out 1: sum valid, held until reset
- `x` in 16: addend
- `y` in 16: addend

## Operation
- Both units use the same state machine: IDLE → RUN → DONE.
- **Reset low** (both units): state=IDLE, all registers 0, `result`=0, `done`=0. This is immediate, regardless of the clock.
- **mult16**
  - IDLE, first edge after reset release: capture x and y into internal registers, clear the product, set the bit counter to 0, go to RUN.
  - RUN: on each edge, if multiplier bit[count] is 1, add multiplicand<<count into the product; increment count.
  - After the 8th RUN edge: go to DONE and set `done`=1.
  - Arithmetic is unsigned; the product always fits in 16 bits.
- **adder16**
  - IDLE, first edge after reset release: capture x and y, clear carry and sum, set the slice counter to 0, go to RUN.
  - RUN: on each edge, add one 4-bit slice (LSB slice first) with the carry-in; store the slice sum and carry-out.
  - After the 4th RUN edge: go to DONE and set `done`=1.
  - The final carry-out is discarded, so the sum wraps modulo 2^16.
- **DONE** (both units): `result` and `done` hold; input changes are ignored. Only reset leaves DONE.
- **Outputs**
  - `result` always drives the internal register; it is never high-Z.
  - During RUN, `result` shows the partial value, which is valid only when `done`=1.
- **Input capture:** inputs are sampled only on the IDLE→RUN edge. Changes after capture do not affect the result.

## Timing
- mult16 latency: 9 rising edges from reset release to `done`=1 (1 capture + 8 RUN). `done` rises on the 9th edge.
- adder16 latency: 5 rising edges (1 capture + 4 RUN).
- `done` is a level, not a pulse. It rises exactly once per reset release, so there is exactly one posedge per operation.
- **Reset asserted mid-RUN:** outputs return to 0 at once and the operation is abandoned. The next release restarts from IDLE with fresh capture.
- **Reset released and asserted within the same cycle:** no capture occurs; the unit stays IDLE.
- **Reset held low across edges:** the unit stays IDLE and `done` stays 0.
- **Chained use:** the adder's reset is tied to the mult's `done`, so the adder starts on the edge after `done` rises. The sum is valid 5 edges later, 14 edges after the mult released.

## Structure
- **Package `mult_add16_pkg`:** `MUL_W`, `SUM_W`, `SLICE_W`, the state enum {IDLE, RUN, DONE}, and the counter widths (3-bit for mult, 2-bit for adder).
- **Sub-module `add_slice4`:** 4-bit ripple adder with carry-in and carry-out. adder16 instantiates it once and reuses it each RUN cycle.
- mult16 uses a plain 16-bit accumulate.
- Each top module contains one FSM process and one datapath process.

## Test plan
- mult16, x=3, y=2, release reset → `done`=0 through edge 8; `done`=1 and `result`=6 at edge 9; both hold for 20 more edges.
- mult16, x=255, y=255 → `result`=65025 (0xFE01), `done` at edge 9. Also x=0, y=200 → `result`=0, `done` at edge 9.
- adder16, x=0xFFFF, y=0x0001 → `result`=0x0000 (wrap), `done` at edge 5. Also x=6, y=100 → `result`=106.
- Reset asserted at RUN edge 3 of mult16 → `result`=0 and `done`=0 immediately. On re-release with x=7, y=9 → `result`=63 at edge 9.
- Change x/y after the capture edge (mult 4*2, then switch to 9*9 mid-RUN) → `result`=8.
- Chained: mult 5*2, adder y=10, adder reset tied to mult `done` → adder `result`=20 and `done`=1 fourteen edges after release.
